// File: rtl/pipe_reg_nlane_pkg.sv
// Shared types and helpers for the multi-lane pipeline register.
package pipe_reg_nlane_pkg;

  // Occupancy encoding doubles as the control FSM state: groups currently held.
  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccFull  = 2'd2
  } occ_e;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/pipe_reg_nlane_if.sv
// Group-level handshake between two pipeline stages, LANES slots per group.
interface pipe_reg_nlane_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DW    = 160
);
  logic [LANES-1:0]    in_valid;
  logic [LANES*DW-1:0] in_data;
  logic                in_ready;
  logic [LANES-1:0]    out_valid;
  logic [LANES*DW-1:0] out_data;
  logic                out_ready;
  logic [1:0]          occ;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occ
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occ
  );
endinterface

// File: rtl/pipe_reg_nlane_slot.sv
// One lane of storage: valid bit plus payload with load and clear controls.
module pipe_lane_slot #(
  parameter int unsigned DW            = 160,
  parameter bit          CLEAR_PAYLOAD = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          clr,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic          keep_payload;

  // Loading an invalid lane counts as the lane becoming invalid.
  assign keep_payload = load_valid | ~CLEAR_PAYLOAD;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= load_valid;
      data_q  <= keep_payload ? load_data : '0;
    end else if (clr) begin
      valid_q <= 1'b0;
      if (CLEAR_PAYLOAD) data_q <= '0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_reg_nlane.sv
// Multi-lane inter-stage pipeline register with a one-group skid buffer,
// per-lane kill, bubble squashing and flush handling.
module pipe_reg_nlane
  import pipe_reg_nlane_pkg::*;
#(
  parameter int unsigned LANES         = 2,
  parameter int unsigned DW            = 160,
  parameter bit          CLEAR_PAYLOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             exception_flush,
  input  logic             stall,
  input  logic [LANES-1:0] kill_mask,
  pipe_reg_nlane_if.slave  bus
);

  occ_e                state_q, state_d;
  logic [LANES-1:0]    main_v, skid_v, main_clr, survivors;
  logic [LANES*DW-1:0] main_data, skid_data;
  logic                main_load, main_from_skid, skid_load, skid_clr;
  logic                do_flush, adv, in_fire, in_ready;

  // in_ready comes from state only, so upstream never waits on out_ready/stall.
  assign in_ready  = (state_q != OccFull);
  assign in_fire   = in_ready & (|bus.in_valid);
  assign adv       = bus.out_ready & ~stall & (state_q != OccEmpty);
  assign do_flush  = exception_flush | (flush & ~stall);
  assign survivors = main_v & ~kill_mask;

  always_ff @(posedge clk) begin
    if (rst) state_q <= OccEmpty;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = '0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (do_flush) begin
      main_clr = '1;
      skid_clr = 1'b1;
      state_d  = OccEmpty;
    end else begin
      unique case (state_q)
        OccEmpty: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = OccOne;
          end
        end
        OccOne: begin
          // Main leaves (advance or killed empty) and may be replaced by the input.
          if (adv || survivors == '0) begin
            if (in_fire) begin
              main_load = 1'b1;
            end else begin
              main_clr = '1;
              state_d  = OccEmpty;
            end
          end else begin
            main_clr = kill_mask;
            if (in_fire) begin
              skid_load = 1'b1;
              state_d   = OccFull;
            end
          end
        end
        OccFull: begin
          if (adv || survivors == '0) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = OccOne;
          end else begin
            main_clr = kill_mask;
          end
        end
        default: state_d = OccEmpty;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic          main_ld_valid;
    logic [DW-1:0] main_ld_data;

    assign main_ld_valid = main_from_skid ? skid_v[i] : bus.in_valid[i];
    assign main_ld_data  = main_from_skid ? skid_data[lane_lsb(i, DW) +: DW]
                                          : bus.in_data[lane_lsb(i, DW) +: DW];

    pipe_lane_slot #(
      .DW           (DW),
      .CLEAR_PAYLOAD(CLEAR_PAYLOAD)
    ) u_main (
      .clk       (clk),
      .rst       (rst),
      .load      (main_load),
      .load_valid(main_ld_valid),
      .load_data (main_ld_data),
      .clr       (main_clr[i]),
      .valid     (main_v[i]),
      .data      (main_data[lane_lsb(i, DW) +: DW])
    );

    pipe_lane_slot #(
      .DW           (DW),
      .CLEAR_PAYLOAD(CLEAR_PAYLOAD)
    ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (skid_load),
      .load_valid(bus.in_valid[i]),
      .load_data (bus.in_data[lane_lsb(i, DW) +: DW]),
      .clr       (skid_clr),
      .valid     (skid_v[i]),
      .data      (skid_data[lane_lsb(i, DW) +: DW])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_v;
  assign bus.out_data  = main_data;
  assign bus.occ       = state_q;

endmodule

// File: tb/tb_pipe_reg_nlane.sv
// Bench for pipe_reg_nlane: three lane counts checked every cycle against a
// small group-queue model, plus directed handshake, flush and kill scenarios.
module tb_pipe_reg_nlane;

  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] d;
  } grp_t;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        exf = 1'b0;
  logic        stall = 1'b0;
  logic        oready = 1'b0;
  logic [3:0]  iv   [NDUT];
  logic [31:0] idat [NDUT];
  logic [3:0]  km   [NDUT];

  grp_t mq   [NDUT][2];
  int   mcnt [NDUT];
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  pipe_reg_nlane_if #(.LANES(2), .DW(16)) b0 ();
  pipe_reg_nlane_if #(.LANES(4), .DW(8))  b1 ();
  pipe_reg_nlane_if #(.LANES(1), .DW(32)) b2 ();

  assign b0.in_valid  = iv[0][1:0];
  assign b0.in_data   = idat[0];
  assign b0.out_ready = oready;
  assign b1.in_valid  = iv[1];
  assign b1.in_data   = idat[1];
  assign b1.out_ready = oready;
  assign b2.in_valid  = iv[2][0:0];
  assign b2.in_data   = idat[2];
  assign b2.out_ready = oready;

  pipe_reg_nlane #(.LANES(2), .DW(16), .CLEAR_PAYLOAD(1'b1)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .exception_flush(exf), .stall(stall),
    .kill_mask(km[0][1:0]), .bus(b0.slave)
  );
  pipe_reg_nlane #(.LANES(4), .DW(8), .CLEAR_PAYLOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .exception_flush(exf), .stall(stall),
    .kill_mask(km[1]), .bus(b1.slave)
  );
  pipe_reg_nlane #(.LANES(1), .DW(32), .CLEAR_PAYLOAD(1'b1)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .exception_flush(exf), .stall(stall),
    .kill_mask(km[2][0:0]), .bus(b2.slave)
  );

  function automatic int lanes_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 4 : 1;
  endfunction

  function automatic logic [3:0] mask_of(input int k);
    return 4'((1 << lanes_of(k)) - 1);
  endfunction

  function automatic logic [31:0] zero_lanes(input logic [3:0] v, input logic [31:0] d,
                                             input int k);
    int dw = 32 / lanes_of(k);
    for (int b = 0; b < 32; b++) if (!v[b / dw]) d[b] = 1'b0;
    return d;
  endfunction

  function automatic logic [3:0] obs_v(input int k);
    case (k)
      0:       return 4'(b0.out_valid);
      1:       return b1.out_valid;
      default: return 4'(b2.out_valid);
    endcase
  endfunction

  function automatic logic [31:0] obs_d(input int k);
    case (k)
      0:       return b0.out_data;
      1:       return b1.out_data;
      default: return b2.out_data;
    endcase
  endfunction

  function automatic logic [2:0] obs_occ_rdy(input int k);
    case (k)
      0:       return {b0.occ, b0.in_ready};
      1:       return {b1.occ, b1.in_ready};
      default: return {b2.occ, b2.in_ready};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop(input int k);
    mq[k][0] = mq[k][1];
    mcnt[k]--;
  endtask

  // Group-level view: a FIFO of at most two groups, head visible at the output.
  task automatic model_update(input int k);
    logic [3:0] m;
    logic       fire, adv;
    grp_t       g;
    m = mask_of(k);
    if (rst || exf || (flush && !stall)) begin
      mcnt[k] = 0;
    end else begin
      fire = (mcnt[k] < 2) && ((iv[k] & m) != 4'b0);
      adv  = oready && !stall && (mcnt[k] > 0);
      if (adv) begin
        pop(k);
      end else if (mcnt[k] > 0) begin
        mq[k][0].v = mq[k][0].v & ~km[k] & m;
        mq[k][0].d = zero_lanes(mq[k][0].v, mq[k][0].d, k);
        if (mq[k][0].v == 4'b0) pop(k);
      end
      if (fire) begin
        g.v = iv[k] & m;
        g.d = zero_lanes(g.v, idat[k], k);
        mq[k][mcnt[k]] = g;
        mcnt[k]++;
      end
    end
  endtask

  task automatic tick();
    grp_t exp;
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) model_update(k);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      exp = (mcnt[k] > 0) ? mq[k][0] : '0;
      check($sformatf("out_valid%0d", k), 32'(obs_v(k)), 32'(exp.v));
      check($sformatf("out_data%0d", k), obs_d(k), exp.d);
      check($sformatf("occ_rdy%0d", k), 32'(obs_occ_rdy(k)),
            32'({2'(mcnt[k]), mcnt[k] < 2}));
    end
  endtask

  initial begin
    logic [31:0] d;
    for (int k = 0; k < NDUT; k++) begin
      iv[k] = '0; idat[k] = '0; km[k] = '0; mcnt[k] = 0;
    end

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_occ", 32'(b0.occ), 32'd0);
    check("reset_rdy", 32'(b0.in_ready), 32'd1);

    // Backpressure into the skid, then drain in order
    iv[0] = 4'b0011; idat[0] = 32'hA1A1_B1B1; tick();
    idat[0] = 32'hA2A2_B2B2; tick();
    check("bp_occ_full", 32'(b0.occ), 32'd2);
    check("bp_rdy_low", 32'(b0.in_ready), 32'd0);
    check("bp_head", b0.out_data, 32'hA1A1_B1B1);
    iv[0] = '0; oready = 1'b1; tick();
    check("bp_second", b0.out_data, 32'hA2A2_B2B2);
    check("bp_occ_one", 32'(b0.occ), 32'd1);
    tick();
    check("bp_drained", 32'(b0.occ), 32'd0);

    // Reset with both registers full
    oready = 1'b0; iv[0] = 4'b0011; idat[0] = 32'h1234_5678; tick(); tick();
    iv[0] = '0; rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_valid", 32'(b0.out_valid), 32'd0);
    check("rst_mid_data", b0.out_data, 32'd0);
    check("rst_mid_occ", 32'(b0.occ), 32'd0);
    check("rst_mid_rdy", 32'(b0.in_ready), 32'd1);

    // Stall blocks flush; exception flush does not
    iv[0] = 4'b0011; idat[0] = 32'hC0C0_C1C1; tick();
    iv[0] = '0; stall = 1'b1; flush = 1'b1; tick();
    check("stall_flush_valid", 32'(b0.out_valid), 32'd3);
    check("stall_flush_occ", 32'(b0.occ), 32'd1);
    flush = 1'b0; exf = 1'b1; tick();
    check("exf_valid", 32'(b0.out_valid), 32'd0);
    check("exf_occ", 32'(b0.occ), 32'd0);
    exf = 1'b0; stall = 1'b0;

    // Kill refill from skid, then a partial kill
    iv[0] = 4'b0011; idat[0] = 32'h1111_2222; tick();
    idat[0] = 32'h3333_4444; tick();
    iv[0] = '0; km[0] = 4'b0011; tick();
    check("kill_refill_data", b0.out_data, 32'h3333_4444);
    check("kill_refill_occ", 32'(b0.occ), 32'd1);
    km[0] = '0; iv[0] = 4'b0011; idat[0] = 32'h5555_6666; tick();
    iv[0] = '0; km[0] = 4'b0010; tick();
    check("kill_part_valid", 32'(b0.out_valid), 32'd1);
    check("kill_part_data", b0.out_data, 32'h0000_4444);
    check("kill_part_occ", 32'(b0.occ), 32'd2);
    km[0] = '0; exf = 1'b1; tick(); exf = 1'b0;

    // Bubble is squashed; then back-to-back groups at full rate
    oready = 1'b1; iv[0] = '0; idat[0] = 32'hDEAD_BEEF; tick();
    check("bubble_occ", 32'(b0.occ), 32'd0);
    for (int t = 0; t < 100; t++) begin
      iv[0] = 4'b0011; idat[0] = $urandom; d = idat[0];
      tick();
      check("tput_data", b0.out_data, d);
      check("tput_valid", 32'(b0.out_valid), 32'd3);
    end
    iv[0] = '0; tick();
    check("tput_end_occ", 32'(b0.occ), 32'd0);

    // Randomised traffic on all lane counts
    for (int t = 0; t < 3000; t++) begin
      rst    = ($urandom_range(0, 199) == 0);
      exf    = ($urandom_range(0, 59) == 0);
      flush  = ($urandom_range(0, 24) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      oready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < NDUT; k++) begin
        iv[k]   = ($urandom_range(0, 4) == 0) ? 4'b0 : (4'($urandom) & mask_of(k));
        idat[k] = $urandom;
        km[k]   = ($urandom_range(0, 5) == 0) ? (4'($urandom) & mask_of(k)) : 4'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
